// File: rtl/imem_loader_if.sv
// Byte stream in, instruction-memory write bus out.
// master = byte source / memory side, slave = imem_loader.
interface imem_loader_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        we;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  modport master (output rx_valid, rx_data, input rx_ready, we, wr_addr, wr_data);
  modport slave  (input rx_valid, rx_data, output rx_ready, we, wr_addr, wr_data);
endinterface

// File: rtl/imem_loader.sv
// imem_loader: serial boot loader. It receives a 4-byte little-endian word
// count N, then N little-endian words, and writes each word to instruction
// memory at BASE_ADDR + 4*k.
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to append a trailing
// checksum byte (modulo-256 sum of the data bytes) that is checked against
// the received data.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 16384
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  imem_loader_if.slave  bus,
  output logic          busy,
  output logic          done,
  output logic          err
);
  // The word counter is at least 15 bits and always wide enough to hold
  // MAX_WORDS, so it cannot wrap.
  localparam int WCW = ($clog2(MAX_WORDS + 1) > 15) ? $clog2(MAX_WORDS + 1) : 15;

  typedef enum logic [2:0] {
    IDLE, HDR, DATA, WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
    CSUM,
`endif
    DONE
  } state_t;

  // State entered once the last word is written, or when the header gives N=0.
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t TAIL = CSUM;
`else
  localparam state_t TAIL = DONE;
`endif

  state_t           state, next;
  logic [1:0]       byte_cnt;
  logic [23:0]      sreg;        // first three bytes of the header or word
  logic [WCW-1:0]   word_cnt;
  logic [WCW-1:0]   word_total;
  logic [WCW:0]     word_nxt;
  logic             accept;
  logic             last_byte;
  logic [31:0]      full_word;
  logic             too_big;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]       csum;
`endif

  assign accept    = bus.rx_valid & bus.rx_ready;
  assign last_byte = accept & (byte_cnt == 2'd3);
  assign full_word = {bus.rx_data, sreg};
  assign too_big   = full_word > 32'(MAX_WORDS);
  assign word_nxt  = {1'b0, word_cnt} + (WCW+1)'(1);

  // All status/handshake outputs are pure decodes of the state register.
  assign bus.rx_ready = (state == HDR) | (state == DATA)
`ifdef IMEM_LOADER_CHECKSUM_EN
                      | (state == CSUM)
`endif
                      ;
  assign bus.we = (state == WRITE);
  assign busy   = (state != IDLE) & (state != DONE);
  assign done   = (state == DONE);

  // State register; reset wins over everything, dropping any partial word.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  // Next-state decode; rx_valid=0 leaves every state except WRITE in place.
  always_comb begin
    next = state;
    case (state)
      IDLE, DONE: if (start) next = HDR;
      HDR: if (last_byte) begin
        if (full_word == 32'd0) next = TAIL;
        else if (too_big)       next = DONE;
        else                    next = DATA;
      end
      DATA:  if (last_byte) next = WRITE;
      WRITE: next = (word_nxt < {1'b0, word_total}) ? DATA : TAIL;
`ifdef IMEM_LOADER_CHECKSUM_EN
      CSUM:  if (accept) next = DONE;
`endif
      default: next = IDLE;
    endcase
  end

  // Datapath: byte assembly, counters, write address/data capture, error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt    <= '0;
      sreg        <= '0;
      word_cnt    <= '0;
      word_total  <= '0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
      err         <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum        <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          err        <= 1'b0;
          byte_cnt   <= '0;
          word_cnt   <= '0;
          word_total <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum       <= '0;
`endif
        end
        HDR: if (accept) begin
          byte_cnt <= byte_cnt + 2'd1;
          sreg     <= {bus.rx_data, sreg[23:8]};
          if (byte_cnt == 2'd3) begin
            word_total <= full_word[WCW-1:0];
            if (too_big) err <= 1'b1;
          end
        end
        DATA: if (accept) begin
          byte_cnt <= byte_cnt + 2'd1;
          sreg     <= {bus.rx_data, sreg[23:8]};
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum     <= csum + bus.rx_data;
`endif
          // Latch the write now so wr_addr/wr_data are registered in WRITE.
          if (byte_cnt == 2'd3) begin
            bus.wr_data <= full_word;
            bus.wr_addr <= BASE_ADDR + (32'(word_cnt) << 2);
          end
        end
        WRITE: word_cnt <= word_nxt[WCW-1:0];
`ifdef IMEM_LOADER_CHECKSUM_EN
        CSUM: if (accept && (bus.rx_data != csum)) err <= 1'b1;
`endif
        default: ;
      endcase
    end
  end
endmodule
